user_id_reader: RTL and testbench
=================================

Name: user_id_reader

Overview:
- Consumes the 32-bit mask_rev constant from the user-ID programming block and captures it into a stable register once the constant cells have settled after reset.
- Presents the captured ID to housekeeping two ways: a parallel read handshake, and a serial shift-out stream (MSB first) for the housekeeping SPI path.
- Sits directly downstream of the ID constant array, inside the housekeeping domain.

Parameters:
- SETTLE_CYCLES, 4, clock cycles after reset release before mask_rev is sampled; legal range 1..255.
- CLK_DIV, 2, wb_clk_i cycles per serial bit; legal range 1..16.

Ports:
- wb_clk_i  input  1  housekeeping clock.
- wb_rstn_i  input  1  asynchronous active-low reset.
- mask_rev  input  32  constant ID from the programming block.
- recapture  input  1  single-cycle pulse; re-runs the settle and capture sequence.
- rd_req  input  1  parallel read request (level).
- rd_ack  output  1  single-cycle read acknowledge.
- rd_data  output  32  captured ID; valid while rd_ack=1.
- id_valid  output  1  high once a capture has completed.
- ser_start  input  1  pulse; starts a serial shift-out.
- ser_data  output  1  serial ID bit.
- ser_strobe  output  1  one-cycle pulse marking the first cycle of each bit.
- ser_busy  output  1  high during a shift-out.

Behaviour:
- Reset (wb_rstn_i=0, asynchronous):
  - Outputs: rd_ack=0, rd_data=0, id_valid=0, ser_data=0, ser_strobe=0, ser_busy=0.
  - Internal: ID register=0, state=SETTLE, settle counter=0.
- States: SETTLE, CAPTURE, IDLE, SHIFT.
- SETTLE: the counter increments every cycle. When counter==SETTLE_CYCLES-1, go to CAPTURE. id_valid=0 throughout.
- CAPTURE (one cycle): ID register<=mask_rev, id_valid<=1, go to IDLE. First id_valid=1 appears SETTLE_CYCLES+1 cycles after reset deassertion.
- IDLE:
  - ser_start=1: load the shift register from the ID register, load bit counter=31, load divider=CLK_DIV-1, go to SHIFT.
  - recapture=1: clear id_valid and the settle counter, go to SETTLE.
  - recapture takes priority over ser_start in the same cycle.
- SHIFT:
  - ser_busy=1. ser_data=current MSB of the shift register.
  - ser_strobe=1 on the first cycle of each bit.
  - Each bit is held for CLK_DIV cycles, so a full transfer lasts 32*CLK_DIV cycles.
  - After bit 0's final cycle, return to IDLE. ser_busy falls and ser_data returns to 0 on the next edge.
  - ser_start during SHIFT is ignored.
  - recapture during SHIFT is deferred: a sticky flag is set and acted on at return to IDLE. The shift completes with the old ID.
- Parallel read:
  - rd_req=1 while id_valid=1 and rd_ack=0: assert rd_ack for exactly one cycle on the next edge, with rd_data=ID register.
  - rd_data returns to 0 when rd_ack=0.
  - A held rd_req produces an ack every other cycle.
  - rd_req while id_valid=0: no ack until capture completes, then ack on the following edge.
  - Parallel reads are served in every state, including SHIFT. They are independent of the serial path.
- Reset asserted mid-shift aborts immediately to the reset values; no partial bits are emitted after reset.
- mask_rev is sampled only in CAPTURE. Changes at any other time do not affect outputs.

Optional Feature:
- Macro: USER_ID_PARITY_EN.
- Defined:
  - Serial stream is 33 bits: the 32 ID bits, then an even-parity bit (XOR of the ID), held for CLK_DIV cycles with its own ser_strobe.
  - Transfer length is 33*CLK_DIV cycles.
  - Extra output port id_parity (1 bit), the registered XOR of the ID register; reset 0.
- Undefined: 32-bit stream, no id_parity port.

Test Plan:
- Reset release with SETTLE_CYCLES=4 and mask_rev=32'hA5C3_0F01 -> id_valid rises on the 5th rising edge after wb_rstn_i=1. rd_req then gives one rd_ack pulse with rd_data=32'hA5C3_0F01.
- rd_req held high from reset -> no ack before id_valid. Then acks alternate every other cycle, each with the correct data, and rd_data=0 between acks.
- ser_start with CLK_DIV=2 and ID=32'h8000_0001 -> ser_busy high for 64 cycles, ser_data high for the first 2 cycles and the last 2 cycles, 32 ser_strobe pulses. With USER_ID_PARITY_EN: 66 cycles, parity bit 0, id_parity=0.
- recapture pulsed mid-shift after mask_rev is changed to 32'h1234_5678 -> shift completes with the old ID, then SETTLE restarts, and id_valid falls and returns with the new ID SETTLE_CYCLES+1 cycles after shift end.
- recapture and ser_start asserted in the same IDLE cycle -> no shift starts, id_valid falls, and a capture occurs.
- wb_rstn_i pulsed low mid-shift at bit 10 -> all outputs go to 0 asynchronously, then a fresh settle/capture sequence runs after release.

Source files
------------

// File: rtl/user_id_reader_if.sv
// Housekeeping-side bundle for the user-ID reader: ID input, parallel read and serial shift-out.
// USER_ID_PARITY_EN adds the id_parity output.
interface user_id_reader_if;
    logic [31:0] mask_rev;
    logic        recapture;
    logic        rd_req;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        id_valid;
    logic        ser_start;
    logic        ser_data;
    logic        ser_strobe;
    logic        ser_busy;
`ifdef USER_ID_PARITY_EN
    logic        id_parity;

    modport master (
        output mask_rev, recapture, rd_req, ser_start,
        input  rd_ack, rd_data, id_valid, ser_data, ser_strobe, ser_busy, id_parity
    );
    modport slave (
        input  mask_rev, recapture, rd_req, ser_start,
        output rd_ack, rd_data, id_valid, ser_data, ser_strobe, ser_busy, id_parity
    );
`else
    modport master (
        output mask_rev, recapture, rd_req, ser_start,
        input  rd_ack, rd_data, id_valid, ser_data, ser_strobe, ser_busy
    );
    modport slave (
        input  mask_rev, recapture, rd_req, ser_start,
        output rd_ack, rd_data, id_valid, ser_data, ser_strobe, ser_busy
    );
`endif
endinterface

// File: rtl/user_id_reader.sv
// Captures mask_rev after a settle delay and serves it via parallel read and MSB-first serial shift-out.
// USER_ID_PARITY_EN appends an even-parity bit to the stream and exposes id_parity.
module user_id_reader #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CLK_DIV       = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rstn_i,
    user_id_reader_if.slave   bus
);
    localparam logic [1:0] ST_SETTLE  = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_IDLE    = 2'd2;
    localparam logic [1:0] ST_SHIFT   = 2'd3;

`ifdef USER_ID_PARITY_EN
    localparam int SH_W = 33;
`else
    localparam int SH_W = 32;
`endif

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD    = 4'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LOAD    = 6'(SH_W - 1);

    logic [1:0]      state;
    logic [7:0]      settle_cnt;
    logic [31:0]     id_reg;
    logic            id_valid_q;
    logic [SH_W-1:0] sh_reg;
    logic [5:0]      bit_cnt;
    logic [3:0]      div_cnt;
    logic            recap_pend;
    logic            rd_ack_q;
    logic [31:0]     rd_data_q;
    logic [SH_W-1:0] sh_load;

`ifdef USER_ID_PARITY_EN
    logic parity_q;
    assign sh_load       = {id_reg, ^id_reg};
    assign bus.id_parity = parity_q;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i)
        if (!wb_rstn_i) parity_q <= 1'b0;
        else            parity_q <= ^id_reg;
`else
    assign sh_load = id_reg;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            id_reg     <= '0;
            id_valid_q <= 1'b0;
            sh_reg     <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            recap_pend <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            // Parallel read path runs in every state; the !rd_ack_q term paces a held request.
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            if (bus.rd_req && id_valid_q && !rd_ack_q) begin
                rd_ack_q  <= 1'b1;
                rd_data_q <= id_reg;
            end

            case (state)
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    id_reg     <= bus.mask_rev;
                    id_valid_q <= 1'b1;
                    state      <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.recapture) begin
                        id_valid_q <= 1'b0;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end else if (bus.ser_start) begin
                        sh_reg  <= sh_load;
                        bit_cnt <= BIT_LOAD;
                        div_cnt <= DIV_LOAD;
                        state   <= ST_SHIFT;
                    end
                end
                default: begin
                    if (bus.recapture) recap_pend <= 1'b1;
                    if (div_cnt == 4'd0) begin
                        if (bit_cnt == 6'd0) begin
                            // A recapture seen during the shift takes effect as the shift ends.
                            if (recap_pend || bus.recapture) begin
                                id_valid_q <= 1'b0;
                                settle_cnt <= '0;
                                recap_pend <= 1'b0;
                                state      <= ST_SETTLE;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            sh_reg  <= {sh_reg[SH_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt - 6'd1;
                            div_cnt <= DIV_LOAD;
                        end
                    end else begin
                        div_cnt <= div_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.id_valid   = id_valid_q;
    assign bus.ser_busy   = (state == ST_SHIFT);
    assign bus.ser_data   = (state == ST_SHIFT) && sh_reg[SH_W-1];
    assign bus.ser_strobe = (state == ST_SHIFT) && (div_cnt == DIV_LOAD);
endmodule

// File: tb/tb_user_id_reader.sv
// Directed self-checking bench for user_id_reader (default SETTLE_CYCLES=4, CLK_DIV=2).
module tb_user_id_reader;
`ifdef USER_ID_PARITY_EN
    localparam int NBITS = 33;
`else
    localparam int NBITS = 32;
`endif

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    user_id_reader_if bus ();

    user_id_reader #(.SETTLE_CYCLES(4), .CLK_DIV(2)) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NBITS-1:0] exp_stream(input logic [31:0] id);
`ifdef USER_ID_PARITY_EN
        return {id, ^id};
`else
        return id;
`endif
    endfunction

    // Reset, release just after an edge, then run the 5 edges to capture.
    task automatic do_reset(input logic [31:0] id);
        rstn = 1'b0;
        bus.mask_rev = id;
        tick;
        tick;
        rstn = 1'b1;
        repeat (5) tick;
    endtask

    // Starts a shift and records it until ser_busy falls (bounded); optionally pulses recapture.
    task automatic collect_shift(input int recap_at, output int busy_n, output int strb_n,
                                 output int hi_n, output logic [NBITS-1:0] stream,
                                 output logic [127:0] map);
        int c;
        busy_n = 0; strb_n = 0; hi_n = 0; stream = '0; map = '0; c = 0;
        bus.ser_start = 1'b1;
        tick;
        bus.ser_start = 1'b0;
        while (bus.ser_busy && c < 120) begin
            busy_n++;
            map[c] = bus.ser_data;
            if (bus.ser_data) hi_n++;
            if (bus.ser_strobe) begin
                strb_n++;
                stream = {stream[NBITS-2:0], bus.ser_data};
            end
            bus.recapture = (c == recap_at);
            tick;
            c++;
        end
        bus.recapture = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        bus.mask_rev = 32'hA5C3_0F01;
        #3;
        checks++;
        if ({bus.rd_ack, bus.rd_data, bus.id_valid, bus.ser_data, bus.ser_strobe, bus.ser_busy} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b data=%h valid=%b sd=%b ss=%b sb=%b, want all 0",
                     bus.rd_ack, bus.rd_data, bus.id_valid, bus.ser_data, bus.ser_strobe, bus.ser_busy);
        end
        tick;
        tick;
        rstn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            checks++;
            if (bus.id_valid !== 1'b0) begin
                errors++;
                $display("FAIL settle_edge%0d: id_valid=%b want 0", i, bus.id_valid);
            end
        end
        tick;
        checks++;
        if (bus.id_valid !== 1'b1) begin
            errors++;
            $display("FAIL capture_edge5: id_valid=%b want 1", bus.id_valid);
        end
        bus.rd_req = 1'b1;
        tick;
        bus.rd_req = 1'b0;
        checks++;
        if (bus.rd_ack !== 1'b1 || bus.rd_data !== 32'hA5C3_0F01) begin
            errors++;
            $display("FAIL first_read: ack=%b data=%h want 1 a5c30f01", bus.rd_ack, bus.rd_data);
        end
        tick;
        checks++;
        if (bus.rd_ack !== 1'b0 || bus.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL read_release: ack=%b data=%h want 0 0", bus.rd_ack, bus.rd_data);
        end
    endtask

    task automatic test_read_held;
        rstn = 1'b0;
        bus.mask_rev = 32'h0BAD_F00D;
        bus.rd_req = 1'b1;
        tick;
        rstn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick;
            checks++;
            if (bus.rd_ack !== 1'b0) begin
                errors++;
                $display("FAIL held_no_early_ack%0d: ack=%b want 0", i, bus.rd_ack);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (i % 2 == 0) begin
                if (bus.rd_ack !== 1'b1 || bus.rd_data !== 32'h0BAD_F00D) begin
                    errors++;
                    $display("FAIL held_ack%0d: ack=%b data=%h want 1 0badf00d", i, bus.rd_ack, bus.rd_data);
                end
            end else if (bus.rd_ack !== 1'b0 || bus.rd_data !== 32'h0) begin
                errors++;
                $display("FAIL held_gap%0d: ack=%b data=%h want 0 0", i, bus.rd_ack, bus.rd_data);
            end
        end
        bus.rd_req = 1'b0;
        tick;
    endtask

    task automatic test_shift;
        int busy_n, strb_n, hi_n;
        logic [NBITS-1:0] stream;
        logic [127:0] map;
        do_reset(32'h8000_0001);
        collect_shift(-1, busy_n, strb_n, hi_n, stream, map);
        checks++;
        if (busy_n != NBITS * 2) begin
            errors++;
            $display("FAIL shift_busy_len: got %0d want %0d", busy_n, NBITS * 2);
        end
        checks++;
        if (strb_n != NBITS) begin
            errors++;
            $display("FAIL shift_strobes: got %0d want %0d", strb_n, NBITS);
        end
        checks++;
        if (hi_n != 4 || {map[0], map[1], map[62], map[63]} !== 4'b1111) begin
            errors++;
            $display("FAIL shift_high_cycles: count=%0d map0_1_62_63=%b want 4 1111",
                     hi_n, {map[0], map[1], map[62], map[63]});
        end
        checks++;
        if (stream !== exp_stream(32'h8000_0001)) begin
            errors++;
            $display("FAIL shift_stream: got %h want %h", stream, exp_stream(32'h8000_0001));
        end
        checks++;
        if (bus.ser_data !== 1'b0 || bus.id_valid !== 1'b1) begin
            errors++;
            $display("FAIL shift_end: ser_data=%b id_valid=%b want 0 1", bus.ser_data, bus.id_valid);
        end
`ifdef USER_ID_PARITY_EN
        checks++;
        if (bus.id_parity !== 1'b0) begin
            errors++;
            $display("FAIL id_parity: got %b want 0", bus.id_parity);
        end
`endif
    endtask

    task automatic test_recapture_mid_shift;
        int busy_n, strb_n, hi_n;
        logic [NBITS-1:0] stream;
        logic [127:0] map;
        bus.mask_rev = 32'h1234_5678;
        collect_shift(20, busy_n, strb_n, hi_n, stream, map);
        checks++;
        if (busy_n != NBITS * 2 || stream !== exp_stream(32'h8000_0001)) begin
            errors++;
            $display("FAIL recap_shift_old_id: len=%0d stream=%h want %0d %h",
                     busy_n, stream, NBITS * 2, exp_stream(32'h8000_0001));
        end
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL recap_valid_drop: id_valid=%b want 0", bus.id_valid);
        end
        repeat (4) tick;
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL recap_valid_early: id_valid=%b want 0", bus.id_valid);
        end
        tick;
        checks++;
        if (bus.id_valid !== 1'b1) begin
            errors++;
            $display("FAIL recap_valid_return: id_valid=%b want 1", bus.id_valid);
        end
        bus.rd_req = 1'b1;
        tick;
        bus.rd_req = 1'b0;
        checks++;
        if (bus.rd_ack !== 1'b1 || bus.rd_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL recap_new_id: ack=%b data=%h want 1 12345678", bus.rd_ack, bus.rd_data);
        end
        tick;
    endtask

    task automatic test_recapture_priority;
        bus.mask_rev = 32'hCAFE_F00D;
        bus.recapture = 1'b1;
        bus.ser_start = 1'b1;
        tick;
        bus.recapture = 1'b0;
        bus.ser_start = 1'b0;
        checks++;
        if (bus.ser_busy !== 1'b0 || bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_no_shift: busy=%b id_valid=%b want 0 0", bus.ser_busy, bus.id_valid);
        end
        repeat (4) tick;
        checks++;
        if (bus.ser_busy !== 1'b0 || bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_settle: busy=%b id_valid=%b want 0 0", bus.ser_busy, bus.id_valid);
        end
        tick;
        bus.rd_req = 1'b1;
        tick;
        bus.rd_req = 1'b0;
        checks++;
        if (bus.rd_ack !== 1'b1 || bus.rd_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL prio_capture: ack=%b data=%h want 1 cafef00d", bus.rd_ack, bus.rd_data);
        end
        tick;
    endtask

    task automatic test_reset_mid_shift;
        bus.ser_start = 1'b1;
        tick;
        bus.ser_start = 1'b0;
        repeat (20) tick;
        checks++;
        if (bus.ser_busy !== 1'b1 || bus.ser_strobe !== 1'b1) begin
            errors++;
            $display("FAIL bit10_start: busy=%b strobe=%b want 1 1", bus.ser_busy, bus.ser_strobe);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.rd_ack, bus.rd_data, bus.id_valid, bus.ser_data, bus.ser_strobe, bus.ser_busy} !== 36'd0) begin
            errors++;
            $display("FAIL async_reset: ack=%b data=%h valid=%b sd=%b ss=%b sb=%b want all 0",
                     bus.rd_ack, bus.rd_data, bus.id_valid, bus.ser_data, bus.ser_strobe, bus.ser_busy);
        end
        bus.mask_rev = 32'h0F0F_1234;
        tick;
        checks++;
        if (bus.ser_busy !== 1'b0 || bus.ser_data !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b data=%b want 0 0", bus.ser_busy, bus.ser_data);
        end
        rstn = 1'b1;
        repeat (4) tick;
        checks++;
        if (bus.id_valid !== 1'b0 || bus.ser_busy !== 1'b0) begin
            errors++;
            $display("FAIL resettle: id_valid=%b busy=%b want 0 0", bus.id_valid, bus.ser_busy);
        end
        tick;
        bus.rd_req = 1'b1;
        tick;
        bus.rd_req = 1'b0;
        checks++;
        if (bus.rd_ack !== 1'b1 || bus.rd_data !== 32'h0F0F_1234) begin
            errors++;
            $display("FAIL reset_recapture: ack=%b data=%h want 1 0f0f1234", bus.rd_ack, bus.rd_data);
        end
        tick;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        bus.mask_rev  = '0;
        bus.recapture = 1'b0;
        bus.rd_req    = 1'b0;
        bus.ser_start = 1'b0;
        test_reset;
        test_read_held;
        test_shift;
        test_recapture_mid_shift;
        test_recapture_priority;
        test_reset_mid_shift;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
